p_hit_iter: RTL and testbench
=============================

Name: p_hit_iter

Overview:
- Parametrised successor to the ray/triangle-plane hit-point stage.
- Per accepted ray, computes t = (n·(v0−origin)) / (n·dir) and the hit point p = origin + t·dir in signed fixed point, using an iterative divider.
- Flags misses: ray parallel to the plane, or plane behind the origin.
- Has FIFO-style input and output handshakes and a parametrised output buffer; sits between ray generation and the barycentric inside-test stage.

Parameters:
- WIDTH, 32, total bits per signed fixed-point coordinate.
- Q_BITS, 16, fractional bits (Q(WIDTH−Q_BITS).Q_BITS).
- OUT_DEPTH, 4, output buffer entries; power of two, ≥2.

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- tri_normal[2:0]  in  WIDTH each  plane normal n, [x,y,z]; sampled with in_wr_en.
- v0[2:0]  in  WIDTH each  triangle vertex 0; sampled with in_wr_en.
- origin[2:0]  in  WIDTH each  ray origin; sampled with in_wr_en.
- dir[2:0]  in  WIDTH each  ray direction; sampled with in_wr_en.
- in_wr_en  in  1  push one ray; ignored while in_full=1.
- in_full  out  1  block cannot accept a ray this cycle.
- out[2:0]  out  WIDTH each  head-of-buffer hit point; zero on a miss.
- out_hit  out  1  head-of-buffer hit flag.
- out_rd_en  in  1  pop head; ignored while out_empty=1.
- out_empty  out  1  output buffer empty.

Behaviour:
- Reset (async, active-high): FSM→IDLE; buffer count, pointers and data registers cleared; out=0, out_hit=0, out_empty=1, in_full=0. In-flight work is discarded, no partial output. Release is synchronous to clock.
- FSM: IDLE → DOT → DIV → SCALE → PUSH → IDLE.
  - IDLE: accepts a ray when in_wr_en=1 and in_full=0, registering all 12 operands.
  - DOT, 1 cycle:
    - num = Σ n_i·(v0_i−origin_i), subtraction at WIDTH+1 bits.
    - den = Σ n_i·dir_i.
    - Products are full width, summed, then arithmetic-shifted right by Q_BITS (truncate toward −∞), held at 2·WIDTH bits.
  - DIV, exactly WIDTH cycles: restoring divide on magnitudes, |t| = (|num|<<Q_BITS)/|den|, truncated toward zero; sign applied after. Always runs full length, even on a miss, so latency is fixed.
  - SCALE, 1 cycle: p_i = origin_i + ((t·dir_i) >>> Q_BITS), wrapped to WIDTH bits (no saturation).
  - PUSH, 1 cycle: writes {p, hit} into the buffer.
- Miss rules:
  - den==0 → miss. The divider is bypassed numerically: no divide-by-zero side effects, quotient forced to 0.
  - num≠0 and sign(num)≠sign(den) → miss (t<0).
  - t==0 is a hit (p=origin).
  - On a miss, stored point = 0 and hit=0.
- Latency: ray accepted at edge k → out_empty falls after edge k+WIDTH+3 (35 cycles at defaults). Throughput is one ray per WIDTH+4 cycles.
- in_full = (state≠IDLE) OR (count + in-flight == OUT_DEPTH), so an accepted ray always has a slot reserved; no overflow is possible.
- Output buffer: first-word fall-through; out/out_hit show the head whenever out_empty=0.
  - Pop and PUSH in the same cycle → count unchanged, data ordering preserved.
  - Pointers wrap modulo OUT_DEPTH.
- in_wr_en while in_full=1, and out_rd_en while out_empty=1, are ignored with no state change.

Decomposition:
- Package p_hit_pkg:
  - fixed-point typedef (signed [WIDTH-1:0]);
  - vec3 typedef;
  - FSM state enum;
  - default WIDTH/Q_BITS constants.
- Sub-module: p_hit_fifo (parametrised first-word fall-through buffer, width 3·WIDTH+1, depth OUT_DEPTH) holding {p, hit}.
- Divider stays inline in the FSM.

Test Plan:
- n=(0,0,0x00010000), v0=(0,0,0x00050000), origin=0, dir=(0,0,0x00010000) → out=(0,0,0x00050000), out_hit=1, out_empty falls 35 cycles after accept.
- Same plane, dir=(0x00010000,0,0x00020000) → t=2.5, out=(0x00028000,0,0x00050000), hit=1.
- Same plane, dir=(0x00010000,0,0) → den=0, out=(0,0,0), hit=0, no X on outputs.
- Same plane, dir=(0,0,0xFFFF0000) → t=−5, miss, out=0, hit=0. Origin=(0,0,0x00050000) with dir +z → t=0, hit, out=origin.
- out_rd_en held low while pushing 5 rays at OUT_DEPTH=4 → in_full stays high after the 4th accept. Then pop once → 5th accepted; all 5 results read back in order.
- Reset asserted mid-DIV on the 2nd ray, with the 1st ray buffered → immediately out_empty=1, in_full=0. A new ray after release gives the correct result; the old results never appear.

Source files
------------

// File: rtl/p_hit_pkg.sv
// Shared types and defaults for the ray/plane hit-point stage.
package p_hit_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_Q_BITS    = 16;
  localparam int DEF_OUT_DEPTH = 4;

  typedef logic signed [DEF_WIDTH-1:0] fix_t;
  typedef fix_t [2:0] vec3_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DOT,
    S_DIV,
    S_SCALE,
    S_PUSH
  } state_t;

endpackage

// File: rtl/p_hit_fifo.sv
// First-word fall-through buffer: rdata shows the head entry whenever empty=0.
module p_hit_fifo #(
  parameter int DW    = 97,
  parameter int DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DW-1:0]           wdata,
  output logic [DW-1:0]           rdata,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/p_hit_iter.sv
// Ray/plane hit point: t = n.(v0-origin) / n.dir via a WIDTH-cycle restoring divider,
// p = origin + t*dir, with miss detection and a FWFT result buffer.
module p_hit_iter
  import p_hit_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int Q_BITS    = DEF_Q_BITS,
  parameter int OUT_DEPTH = DEF_OUT_DEPTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] tri_normal [2:0],
  input  logic signed [WIDTH-1:0] v0         [2:0],
  input  logic signed [WIDTH-1:0] origin     [2:0],
  input  logic signed [WIDTH-1:0] dir        [2:0],
  input  logic                    in_wr_en,
  output logic                    in_full,
  output logic signed [WIDTH-1:0] out        [2:0],
  output logic                    out_hit,
  input  logic                    out_rd_en,
  output logic                    out_empty
);

  localparam int PW   = 2 * WIDTH;
  localparam int SUMW = 2 * WIDTH + 3;
  localparam int REMW = 2 * WIDTH + 2;
  localparam int CW   = $clog2(WIDTH);
  localparam int FW   = 3 * WIDTH + 1;

  state_t                  state_q, state_d;
  logic [2:0][WIDTH-1:0]   n_q, n_d, v0_q, v0_d, org_q, org_d, dir_q, dir_d;
  logic                    miss_q, miss_d, neg_q, neg_d, zero_q, zero_d;
  logic [PW-1:0]           dmag_q, dmag_d;
  logic [REMW-1:0]         rem_q, rem_d;
  logic [WIDTH-1:0]        dlo_q, dlo_d, quo_q, quo_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [2:0][WIDTH-1:0]   p_q, p_d;
  logic                    hit_q, hit_d;

  logic signed [WIDTH:0]   diff      [3];
  logic signed [SUMW-1:0]  num_prod  [3];
  logic signed [SUMW-1:0]  den_prod  [3];
  logic signed [WIDTH-1:0] p_calc    [3];
  logic signed [SUMW-1:0]  num_sum, den_sum;
  logic signed [PW-1:0]    num_w, den_w;
  logic [PW-1:0]           num_mag, den_mag;
  logic [PW+Q_BITS-1:0]    dvd;
  logic                    den_zero, t_neg;
  logic [REMW:0]           trial, dmag_ext;
  logic                    qbit;
  logic signed [WIDTH-1:0] t_s;

  logic                    busy, accept, fifo_empty;
  logic [FW-1:0]           fifo_rdata;
  logic [$clog2(OUT_DEPTH):0] fifo_count;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      assign diff[gi]     = (WIDTH+1)'($signed(v0_q[gi])) - (WIDTH+1)'($signed(org_q[gi]));
      assign num_prod[gi] = SUMW'($signed(n_q[gi])) * SUMW'(diff[gi]);
      assign den_prod[gi] = SUMW'($signed(n_q[gi])) * SUMW'($signed(dir_q[gi]));
      // Product is kept at 2*WIDTH, then rescaled and wrapped back to WIDTH bits.
      assign p_calc[gi]   = $signed(org_q[gi])
                          + WIDTH'((PW'(t_s) * PW'($signed(dir_q[gi]))) >>> Q_BITS);
      assign out[gi]      = fifo_empty ? '0 : fifo_rdata[gi*WIDTH+1 +: WIDTH];
    end
  endgenerate

  assign num_sum  = num_prod[0] + num_prod[1] + num_prod[2];
  assign den_sum  = den_prod[0] + den_prod[1] + den_prod[2];
  assign num_w    = PW'(num_sum >>> Q_BITS);
  assign den_w    = PW'(den_sum >>> Q_BITS);
  assign num_mag  = num_w[PW-1] ? -num_w : num_w;
  assign den_mag  = den_w[PW-1] ? -den_w : den_w;
  assign dvd      = {num_mag, {Q_BITS{1'b0}}};
  assign den_zero = (den_w == '0);
  assign t_neg    = num_w[PW-1] ^ den_w[PW-1];

  // A zero denominator never sets a quotient bit, so the result stays 0.
  assign trial    = {rem_q, dlo_q[WIDTH-1]};
  assign dmag_ext = (REMW+1)'(dmag_q);
  assign qbit     = !zero_q && (trial >= dmag_ext);
  assign t_s      = neg_q ? -$signed(quo_q) : $signed(quo_q);

  assign busy    = (state_q != S_IDLE);
  assign in_full = busy || (32'(fifo_count) + 32'(busy) == 32'(OUT_DEPTH));
  assign accept  = in_wr_en && !in_full;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    v0_d    = v0_q;
    org_d   = org_q;
    dir_d   = dir_q;
    miss_d  = miss_q;
    neg_d   = neg_q;
    zero_d  = zero_q;
    dmag_d  = dmag_q;
    rem_d   = rem_q;
    dlo_d   = dlo_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    hit_d   = hit_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          for (int i = 0; i < 3; i++) begin
            n_d[i]   = tri_normal[i];
            v0_d[i]  = v0[i];
            org_d[i] = origin[i];
            dir_d[i] = dir[i];
          end
          state_d = S_DOT;
        end
      end
      S_DOT: begin
        zero_d  = den_zero;
        neg_d   = t_neg;
        miss_d  = den_zero || ((num_w != '0) && t_neg);
        dmag_d  = den_mag;
        rem_d   = REMW'(dvd[PW+Q_BITS-1:WIDTH]);
        dlo_d   = dvd[WIDTH-1:0];
        quo_d   = '0;
        cnt_d   = '0;
        state_d = S_DIV;
      end
      S_DIV: begin
        rem_d = qbit ? REMW'(trial - dmag_ext) : REMW'(trial);
        dlo_d = {dlo_q[WIDTH-2:0], 1'b0};
        quo_d = {quo_q[WIDTH-2:0], qbit};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) state_d = S_SCALE;
      end
      S_SCALE: begin
        for (int i = 0; i < 3; i++) p_d[i] = miss_q ? '0 : p_calc[i];
        hit_d   = !miss_q;
        state_d = S_PUSH;
      end
      S_PUSH:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      v0_q    <= '0;
      org_q   <= '0;
      dir_q   <= '0;
      miss_q  <= 1'b0;
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
      dmag_q  <= '0;
      rem_q   <= '0;
      dlo_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      v0_q    <= v0_d;
      org_q   <= org_d;
      dir_q   <= dir_d;
      miss_q  <= miss_d;
      neg_q   <= neg_d;
      zero_q  <= zero_d;
      dmag_q  <= dmag_d;
      rem_q   <= rem_d;
      dlo_q   <= dlo_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      hit_q   <= hit_d;
    end
  end

  p_hit_fifo #(
    .DW    (FW),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (state_q == S_PUSH),
    .pop   (out_rd_en),
    .wdata ({p_q, hit_q}),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign out_empty = fifo_empty;
  assign out_hit   = fifo_empty ? 1'b0 : fifo_rdata[0];

endmodule

// File: tb/tb_p_hit_iter.sv
// Directed vector bench for p_hit_iter: table of rays with hand-computed hit points,
// plus buffer-full and mid-divide reset sequences.
module tb_p_hit_iter;

  localparam int W = 32;

  logic                clock = 1'b0;
  logic                reset;
  logic signed [W-1:0] tri_normal [2:0];
  logic signed [W-1:0] v0         [2:0];
  logic signed [W-1:0] origin     [2:0];
  logic signed [W-1:0] dir        [2:0];
  logic signed [W-1:0] out        [2:0];
  logic                in_wr_en, in_full, out_hit, out_rd_en, out_empty;

  p_hit_iter #(.WIDTH(32), .Q_BITS(16), .OUT_DEPTH(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .tri_normal (tri_normal),
    .v0         (v0),
    .origin     (origin),
    .dir        (dir),
    .in_wr_en   (in_wr_en),
    .in_full    (in_full),
    .out        (out),
    .out_hit    (out_hit),
    .out_rd_en  (out_rd_en),
    .out_empty  (out_empty)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0][31:0] n;
    logic [2:0][31:0] v;
    logic [2:0][31:0] o;
    logic [2:0][31:0] d;
    logic [2:0][31:0] ep;
    logic             eh;
  } vec_t;

  vec_t tbl [8];
  int   checks = 0;
  int   passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    checks++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  task automatic set_vec(input int i,
                         input logic [31:0] nx, ny, nz, vx, vy, vz,
                         input logic [31:0] ox, oy, oz, dx, dy, dz,
                         input logic [31:0] px, py, pz, input logic h);
    vec_t r;
    r.n  = {nz, ny, nx};
    r.v  = {vz, vy, vx};
    r.o  = {oz, oy, ox};
    r.d  = {dz, dy, dx};
    r.ep = {pz, py, px};
    r.eh = h;
    tbl[i] = r;
  endtask

  task automatic drive(input vec_t r);
    for (int i = 0; i < 3; i++) begin
      tri_normal[i] = r.n[i];
      v0[i]         = r.v[i];
      origin[i]     = r.o[i];
      dir[i]        = r.d[i];
    end
  endtask

  task automatic send(input vec_t r);
    int g = 0;
    while (in_full && g < 200) begin
      @(posedge clock); #1; g++;
    end
    if (in_full) timeout("send_wait");
    drive(r);
    in_wr_en = 1'b1;
    @(posedge clock); #1;
    in_wr_en = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (out_empty && cyc < 100) begin
      @(posedge clock); #1; cyc++;
    end
    if (out_empty) timeout("out_wait");
  endtask

  task automatic check_head(input string tag, input vec_t r);
    $display("%s: p=(%h,%h,%h) hit=%0d", tag, out[0], out[1], out[2], out_hit);
    chk({tag, "_px"}, out[0], r.ep[0]);
    chk({tag, "_py"}, out[1], r.ep[1]);
    chk({tag, "_pz"}, out[2], r.ep[2]);
    chk({tag, "_hit"}, 32'(out_hit), 32'(r.eh));
  endtask

  task automatic pop();
    out_rd_en = 1'b1;
    @(posedge clock); #1;
    out_rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int   cyc;
    int   ord [5];
    vec_t junk;

    reset     = 1'b1;
    in_wr_en  = 1'b0;
    out_rd_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tri_normal[i] = '0; v0[i] = '0; origin[i] = '0; dir[i] = '0;
    end

    //      n                       v0                      origin                  dir                         expected p                   hit
    set_vec(0, 0,0,32'h10000,        0,0,32'h50000,          0,0,0,                  0,0,32'h10000,              0,0,32'h50000,               1);
    set_vec(1, 0,0,32'h10000,        0,0,32'h50000,          0,0,0,                  32'h10000,0,32'h20000,      32'h28000,0,32'h50000,       1);
    set_vec(2, 0,0,32'h10000,        0,0,32'h50000,          0,0,0,                  32'h10000,0,0,              0,0,0,                       0);
    set_vec(3, 0,0,32'h10000,        0,0,32'h50000,          0,0,0,                  0,0,32'hFFFF0000,           0,0,0,                       0);
    set_vec(4, 0,0,32'h10000,        0,0,32'h50000,          0,0,32'h50000,          0,0,32'h10000,              0,0,32'h50000,               1);
    set_vec(5, 0,0,32'h10000,        0,0,32'hFFFB0000,       32'h30000,0,0,          0,0,32'hFFFF0000,           32'h30000,0,32'hFFFB0000,    1);
    set_vec(6, 0,0,32'h10000,        0,0,32'h10000,          0,0,0,                  0,0,32'h30000,              0,0,32'h0000FFFF,            1);
    set_vec(7, 32'h10000,32'h10000,0, 32'h20000,0,0,         0,0,0,                  32'h10000,0,0,              32'h20000,0,0,               1);

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_empty", 32'(out_empty), 32'd1);
    chk("rst_full",  32'(in_full),   32'd0);
    chk("rst_hit",   32'(out_hit),   32'd0);
    chk("rst_pz",    out[2],         32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Single rays through the table
    for (int i = 0; i < 8; i++) begin
      send(tbl[i]);
      wait_out(cyc);
      chk($sformatf("v%0d_lat", i), 32'(cyc), 32'd35);
      check_head($sformatf("v%0d", i), tbl[i]);
      pop();
      chk($sformatf("v%0d_drain", i), 32'(out_empty), 32'd1);
    end

    // Buffer fills with no reads; fifth ray waits for a pop
    ord = '{0, 1, 4, 5, 6};
    for (int j = 0; j < 4; j++) send(tbl[ord[j]]);
    chk("fill_full_busy", 32'(in_full), 32'd1);
    repeat (50) begin @(posedge clock); #1; end
    chk("fill_full_idle", 32'(in_full), 32'd1);
    chk("fill_nonempty",  32'(out_empty), 32'd0);
    junk = tbl[7];
    drive(junk);
    in_wr_en = 1'b1;
    @(posedge clock); #1;
    in_wr_en = 1'b0;
    chk("fill_ignored", 32'(in_full), 32'd1);
    check_head("fill0", tbl[ord[0]]);
    pop();
    chk("fill_room", 32'(in_full), 32'd0);
    send(tbl[ord[4]]);
    repeat (40) begin @(posedge clock); #1; end
    for (int j = 1; j < 5; j++) begin
      check_head($sformatf("fill%0d", j), tbl[ord[j]]);
      pop();
    end
    chk("fill_drained", 32'(out_empty), 32'd1);

    // Reset while the second ray is dividing and the first is buffered
    send(tbl[0]);
    wait_out(cyc);
    send(tbl[1]);
    repeat (10) begin @(posedge clock); #1; end
    reset = 1'b1;
    #1;
    chk("mid_rst_empty", 32'(out_empty), 32'd1);
    chk("mid_rst_full",  32'(in_full),   32'd0);
    chk("mid_rst_hit",   32'(out_hit),   32'd0);
    chk("mid_rst_pz",    out[2],         32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    send(tbl[7]);
    wait_out(cyc);
    chk("post_rst_lat", 32'(cyc), 32'd35);
    check_head("post_rst", tbl[7]);
    pop();
    repeat (60) begin @(posedge clock); #1; end
    chk("post_rst_no_stale", 32'(out_empty), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
